// File: rtl/intc_pkg.sv
// Shared types for the interrupt priority arbiter: FSM state encoding and NMI priority.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    ACKED = 2'd2
  } intc_state_e;

  // NMI is always presented with an all-ones priority; consumers slice the low PRIO_W bits.
  localparam logic [31:0] NMI_PRIO_ALL = 32'hFFFF_FFFF;

endpackage

// File: rtl/intc_max_prio_tree.sv
// Combinational selection of the highest-priority eligible source; lowest index wins ties.
module intc_max_prio_tree #(
  parameter int N_SRC  = 240,
  parameter int PRIO_W = 3,
  localparam int IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0]        elig,
  input  logic [N_SRC*PRIO_W-1:0] prio,
  output logic                    best_valid,
  output logic [IDX_W-1:0]        best_idx,
  output logic [PRIO_W-1:0]       best_prio
);

  // Strict greater-than keeps the first (lowest-index) source among equals.
  always_comb begin
    best_prio = '0;
    best_idx  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (elig[i] && (prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio = prio[i*PRIO_W +: PRIO_W];
        best_idx  = IDX_W'(i);
      end
    end
    best_valid = |best_prio;
  end

endmodule

// File: rtl/intc_prio_arbiter.sv
// Interrupt priority arbiter: registered candidate stage, edge-latched NMI and a present/ack FSM.
// Optional round-robin tie-break among equal priorities with INTC_RR_TIEBREAK_EN.
module intc_prio_arbiter
  import intc_pkg::*;
#(
  parameter int N_SRC    = 240,
  parameter int PRIO_W   = 3,
  parameter int VEC_W    = 8,
  parameter int VEC_BASE = 64,
  parameter int NMI_VEC  = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SRC-1:0]          src_req,
  input  logic [N_SRC*PRIO_W-1:0]   src_prio,
  input  logic                      mode,
  input  logic                      i_bit,
  input  logic [PRIO_W-1:0]         mask_level,
  input  logic                      nmi_req,
  input  logic                      irq_ack,
  output logic                      irq_valid,
  output logic [VEC_W-1:0]          irq_vector,
  output logic [PRIO_W-1:0]         irq_prio,
  output logic [$clog2(N_SRC)-1:0]  irq_src
);

  localparam int IDX_W = $clog2(N_SRC);

  // Handshake: irq_valid stays high with stable vector/prio/src until a one-cycle
  // irq_ack is seen while presenting; irq_ack at any other time has no effect.

  logic [N_SRC-1:0]  elig;
  logic [PRIO_W-1:0] p_i;

  always_comb begin
    elig = '0;
    p_i  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      p_i     = src_prio[i*PRIO_W +: PRIO_W];
      elig[i] = src_req[i] && (p_i != '0) && (mode ? (p_i > mask_level) : !i_bit);
    end
  end

  logic              all_valid;
  logic [IDX_W-1:0]  all_idx;
  logic [PRIO_W-1:0] all_prio;
  logic              sel_valid;
  logic [IDX_W-1:0]  sel_idx;
  logic [PRIO_W-1:0] sel_prio;

  intc_max_prio_tree #(.N_SRC(N_SRC), .PRIO_W(PRIO_W)) u_tree_all (
    .elig       (elig),
    .prio       (src_prio),
    .best_valid (all_valid),
    .best_idx   (all_idx),
    .best_prio  (all_prio)
  );

  intc_state_e       state_q, state_d;
  logic              is_nmi, is_nmi_d;

`ifdef INTC_RR_TIEBREAK_EN
  logic [IDX_W-1:0]  rr_ptr;
  logic [N_SRC-1:0]  elig_hi;
  logic              hi_valid;
  logic [IDX_W-1:0]  hi_idx;
  logic [PRIO_W-1:0] hi_prio;

  always_comb begin
    elig_hi = '0;
    for (int i = 0; i < N_SRC; i++) begin
      elig_hi[i] = elig[i] && (IDX_W'(i) >= rr_ptr);
    end
  end

  intc_max_prio_tree #(.N_SRC(N_SRC), .PRIO_W(PRIO_W)) u_tree_hi (
    .elig       (elig_hi),
    .prio       (src_prio),
    .best_valid (hi_valid),
    .best_idx   (hi_idx),
    .best_prio  (hi_prio)
  );

  // A source at or after the pointer that reaches the global max priority wins; else wrap.
  always_comb begin
    sel_valid = all_valid;
    sel_prio  = all_prio;
    sel_idx   = (hi_valid && (hi_prio == all_prio)) ? hi_idx : all_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if ((state_q == PEND) && irq_ack && !is_nmi) begin
      rr_ptr <= (int'(irq_src) == N_SRC - 1) ? '0 : irq_src + 1'b1;
    end
  end
`else
  always_comb begin
    sel_valid = all_valid;
    sel_idx   = all_idx;
    sel_prio  = all_prio;
  end
`endif

  logic              cand_valid;
  logic [IDX_W-1:0]  cand_idx;
  logic [PRIO_W-1:0] cand_prio;
  logic [VEC_W-1:0]  cand_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_valid <= 1'b0;
      cand_idx   <= '0;
      cand_prio  <= '0;
    end else begin
      cand_valid <= sel_valid;
      cand_idx   <= sel_idx;
      cand_prio  <= sel_prio;
    end
  end

  assign cand_vec = VEC_W'(VEC_BASE + int'(cand_idx));

  logic nmi_q, nmi_latch, nmi_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_q     <= 1'b0;
      nmi_latch <= 1'b0;
    end else begin
      nmi_q     <= nmi_req;
      nmi_latch <= (nmi_req && !nmi_q) || (nmi_latch && !nmi_clr);
    end
  end

  logic              valid_d;
  logic [VEC_W-1:0]  vec_d;
  logic [PRIO_W-1:0] prio_d;
  logic [IDX_W-1:0]  src_d;

  always_comb begin
    state_d  = state_q;
    valid_d  = irq_valid;
    vec_d    = irq_vector;
    prio_d   = irq_prio;
    src_d    = irq_src;
    is_nmi_d = is_nmi;
    nmi_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (nmi_latch) begin
          state_d  = PEND;
          valid_d  = 1'b1;
          vec_d    = VEC_W'(NMI_VEC);
          prio_d   = NMI_PRIO_ALL[PRIO_W-1:0];
          src_d    = '0;
          is_nmi_d = 1'b1;
        end else if (cand_valid) begin
          state_d  = PEND;
          valid_d  = 1'b1;
          vec_d    = cand_vec;
          prio_d   = cand_prio;
          src_d    = cand_idx;
          is_nmi_d = 1'b0;
        end
      end
      PEND: begin
        if (irq_ack) begin
          state_d = ACKED;
          valid_d = 1'b0;
          nmi_clr = is_nmi;
        end else if (nmi_latch && !is_nmi) begin
          vec_d    = VEC_W'(NMI_VEC);
          prio_d   = NMI_PRIO_ALL[PRIO_W-1:0];
          src_d    = '0;
          is_nmi_d = 1'b1;
        end else if (!is_nmi && !elig[irq_src]) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      ACKED: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      irq_valid  <= 1'b0;
      irq_vector <= '0;
      irq_prio   <= '0;
      irq_src    <= '0;
      is_nmi     <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_valid  <= valid_d;
      irq_vector <= vec_d;
      irq_prio   <= prio_d;
      irq_src    <= src_d;
      is_nmi     <= is_nmi_d;
    end
  end

endmodule

// File: tb/tb_intc_prio_arbiter.sv
// Directed bench for intc_prio_arbiter: vector table for static arbitration plus
// hand sequences for ack, NMI replacement, withdrawal and reset corner cases.
module tb_intc_prio_arbiter;
  import intc_pkg::*;

  localparam int N_SRC  = 240;
  localparam int PRIO_W = 3;
  localparam int VEC_W  = 8;
  localparam int IDX_W  = $clog2(N_SRC);

  logic                     clk;
  logic                     rst;
  logic [N_SRC-1:0]         src_req;
  logic [N_SRC*PRIO_W-1:0]  src_prio;
  logic                     mode;
  logic                     i_bit;
  logic [PRIO_W-1:0]        mask_level;
  logic                     nmi_req;
  logic                     irq_ack;
  logic                     irq_valid;
  logic [VEC_W-1:0]         irq_vector;
  logic [PRIO_W-1:0]        irq_prio;
  logic [IDX_W-1:0]         irq_src;

  int checks = 0;
  int errors = 0;

  intc_prio_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .src_req    (src_req),
    .src_prio   (src_prio),
    .mode       (mode),
    .i_bit      (i_bit),
    .mask_level (mask_level),
    .nmi_req    (nmi_req),
    .irq_ack    (irq_ack),
    .irq_valid  (irq_valid),
    .irq_vector (irq_vector),
    .irq_prio   (irq_prio),
    .irq_src    (irq_src)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src_req    = '0;
    src_prio   = '0;
    mode       = 1'b0;
    i_bit      = 1'b0;
    mask_level = '0;
    nmi_req    = 1'b0;
    irq_ack    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_src(input int idx, input int p);
    src_req[idx] = 1'b1;
    src_prio[idx*PRIO_W +: PRIO_W] = PRIO_W'(p);
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int v, input int vec, input int p, input int s);
    check({tag, "_valid"},  32'(irq_valid),  32'(v));
    check({tag, "_vector"}, 32'(irq_vector), 32'(vec));
    check({tag, "_prio"},   32'(irq_prio),   32'(p));
    check({tag, "_src"},    32'(irq_src),    32'(s));
  endtask

  typedef struct {
    int a_idx;
    int a_prio;
    int b_idx;
    int b_prio;
    bit mode;
    bit ibit;
    int mask;
    bit exp_valid;
    int exp_src;
    int exp_vec;
    int exp_prio;
  } vec_t;

  vec_t tbl[9];
  int   exp_rr_src;

  initial begin
    tbl[0] = '{5,   4, 9,   4, 1'b1, 1'b0, 2, 1'b1, 5,   69,  4};
    tbl[1] = '{3,   2, -1,  0, 1'b1, 1'b0, 2, 1'b0, 0,   0,   0};
    tbl[2] = '{3,   2, -1,  0, 1'b1, 1'b0, 1, 1'b1, 3,   67,  2};
    tbl[3] = '{10,  5, -1,  0, 1'b0, 1'b1, 0, 1'b0, 0,   0,   0};
    tbl[4] = '{10,  5, 20,  6, 1'b0, 1'b0, 0, 1'b1, 20,  84,  6};
    tbl[5] = '{0,   0, 1,   0, 1'b0, 1'b0, 0, 1'b0, 0,   0,   0};
    tbl[6] = '{239, 7, -1,  0, 1'b1, 1'b0, 6, 1'b1, 239, 47,  7};
    tbl[7] = '{100, 7, -1,  0, 1'b1, 1'b0, 7, 1'b0, 0,   0,   0};
    tbl[8] = '{200, 1, 150, 1, 1'b0, 1'b0, 0, 1'b1, 150, 214, 1};

    do_reset();
    check_outs("reset", 0, 0, 0, 0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));

    // static arbitration vectors: 2-cycle latency, then presented outputs
    for (int k = 0; k < 9; k++) begin
      do_reset();
      mode       = tbl[k].mode;
      i_bit      = tbl[k].ibit;
      mask_level = PRIO_W'(tbl[k].mask);
      set_src(tbl[k].a_idx, tbl[k].a_prio);
      if (tbl[k].b_idx >= 0) set_src(tbl[k].b_idx, tbl[k].b_prio);
      tick();
      check($sformatf("vec%0d_lat1", k), 32'(irq_valid), 32'd0);
      tick();
      check_outs($sformatf("vec%0d", k), int'(tbl[k].exp_valid), tbl[k].exp_vec,
                 tbl[k].exp_prio, tbl[k].exp_src);
    end

    // ack -> ACKED for one cycle, then the held pair is re-presented
`ifdef INTC_RR_TIEBREAK_EN
    exp_rr_src = 9;
`else
    exp_rr_src = 5;
`endif
    do_reset();
    mode = 1'b1;
    mask_level = 3'd2;
    set_src(5, 4);
    set_src(9, 4);
    tick();
    tick();
    check_outs("ack_first", 1, 69, 4, 5);
    pulse_ack();
    check("ack_acked_valid", 32'(irq_valid), 32'd0);
    check("ack_acked_state", 32'(dut.state_q), 32'(ACKED));
    tick();
    check("ack_idle_valid", 32'(irq_valid), 32'd0);
    check("ack_idle_state", 32'(dut.state_q), 32'(IDLE));
    tick();
    check_outs("ack_second", 1, 64 + exp_rr_src, 4, exp_rr_src);

    // NMI replaces a pending maskable request; its ack clears the latch
    do_reset();
    mode = 1'b1;
    mask_level = 3'd2;
    set_src(5, 4);
    tick();
    tick();
    check_outs("nmi_pre", 1, 69, 4, 5);
    nmi_req = 1'b1;
    tick();
    check_outs("nmi_latching", 1, 69, 4, 5);
    tick();
    check_outs("nmi_replace", 1, 7, 7, 0);
    pulse_ack();
    check("nmi_acked_valid", 32'(irq_valid), 32'd0);
    tick();
    check("nmi_idle_valid", 32'(irq_valid), 32'd0);
    tick();
    check_outs("nmi_cleared", 1, 69, 4, 5);

    // withdrawal by deassertion
    do_reset();
    mode = 1'b1;
    mask_level = 3'd2;
    set_src(5, 4);
    tick();
    tick();
    check("wd_pend_valid", 32'(irq_valid), 32'd1);
    src_req[5] = 1'b0;
    tick();
    check("wd_drop_valid", 32'(irq_valid), 32'd0);
    check("wd_drop_state", 32'(dut.state_q), 32'(IDLE));
    tick();
    check("wd_stay_valid", 32'(irq_valid), 32'd0);

    // withdrawal by losing eligibility
    do_reset();
    mode = 1'b1;
    mask_level = 3'd2;
    set_src(5, 4);
    tick();
    tick();
    check("mask_pend_valid", 32'(irq_valid), 32'd1);
    mask_level = 3'd4;
    tick();
    check("mask_drop_valid", 32'(irq_valid), 32'd0);

    // reset mid-PEND with a latched NMI
    do_reset();
    mode = 1'b1;
    mask_level = 3'd2;
    set_src(5, 4);
    tick();
    tick();
    nmi_req = 1'b1;
    tick();
    rst = 1'b1;
    clear_inputs();
    tick();
    check_outs("rst_mid", 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("rst_latch_gone", 32'(irq_valid), 32'd0);

    // NMI high through reset counts as one edge afterwards
    rst = 1'b1;
    clear_inputs();
    nmi_req = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("nmi_rst_lat1", 32'(irq_valid), 32'd0);
    tick();
    check_outs("nmi_rst_edge", 1, 7, 7, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
